tcm_pmem_axi: RTL and testbench
===============================

TCM_PMEM_AXI -- requirements
Module: tcm_pmem_axi

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0, the ID driven on awid_o/arid_o.
REQ-002 SHALL have parameter MAX_LEN, default 8'd7, the largest accepted ram_len_i (beats-1).
REQ-003 clk_i  in  1  sole clock; all logic rising-edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 ram_rd_i  in  1; ram_wr_i  in  4; ram_len_i  in  8; ram_addr_i  in  32; ram_write_data_i  in  32: pmem requests (beats-1 in len, byte strobes in wr).
REQ-006 ram_accept_o  out  1; ram_ack_o  out  1; ram_error_o  out  1; ram_read_data_o  out  32: pmem responses.
REQ-007 axi_awvalid_o out 1, axi_awaddr_o out 32, axi_awid_o out 4, axi_awlen_o out 8, axi_awburst_o out 2, axi_awready_i in 1.
REQ-008 axi_wvalid_o out 1, axi_wdata_o out 32, axi_wstrb_o out 4, axi_wlast_o out 1, axi_wready_i in 1.
REQ-009 axi_bvalid_i in 1, axi_bresp_i in 2, axi_bid_i in 4, axi_bready_o out 1.
REQ-010 axi_arvalid_o out 1, axi_araddr_o out 32, axi_arid_o out 4, axi_arlen_o out 8, axi_arburst_o out 2, axi_arready_i in 1.
REQ-011 axi_rvalid_i in 1, axi_rdata_i in 32, axi_rresp_i in 2, axi_rid_i in 4, axi_rlast_i in 1, axi_rready_o out 1.

Function
REQ-012 SHALL be the AXI4 initiator mirroring the TCM's AXI responder: one transaction outstanding, INCR bursts (awburst/arburst = 2'b01), ID = AXI_ID.
REQ-013 FSM states: IDLE, WRITE, WRESP, RADDR, RDATA.
REQ-014 IDLE: ram_accept_o = 1; a beat is a request with ram_rd_i or ram_wr_i != 0 and ram_accept_o.
REQ-015 IDLE write beat: register addr[31:2],2'b00 and len into AW, load beat into W holding register, assert awvalid/wvalid next cycle, go WRITE; wlast = 1 iff len = 0.
REQ-016 WRITE: awvalid held until awready, then cleared; W register drained on wvalid&wready; ram_accept_o = !W_full | wready; ram_wr_i = 0 beats ignored.
REQ-017 Beat counter decrements per W handshake; wlast asserted on final beat; after final W and AW both handshaken go WRESP (AW and W completion order arbitrary, either may precede).
REQ-018 WRESP: bready_o = 1; on bvalid pulse ram_ack_o 1 cycle, ram_error_o = (bresp != 2'b00), return IDLE; write burst acknowledged once per burst.
REQ-019 IDLE read: register address/len, arvalid next cycle, go RADDR; ram_accept_o = 0 outside IDLE except WRITE data beats.
REQ-020 RADDR: hold arvalid until arready, go RDATA. RDATA: rready_o = 1; each rvalid -> ram_ack_o 1 cycle, ram_read_data_o = rdata (registered, 1-cycle latency), ram_error_o = (rresp != 0); rlast -> IDLE.
REQ-021 Simultaneous ram_rd_i and ram_wr_i != 0 in IDLE: write wins, read not accepted.
REQ-022 ram_len_i > MAX_LEN: clamped to MAX_LEN; ram_error_o asserted on that burst's ack.
REQ-023 Responses with bid/rid != AXI_ID: still consumed, error flagged.
REQ-024 AXI outputs SHALL be registered; valid, once asserted, held with stable payload until ready (AXI stability rule).

Reset
REQ-025 On rst_i low, asynchronously: state IDLE, all valids/readies/ack/error 0, ram_accept_o 1 after deassertion, data/address registers 0.
REQ-026 Reset mid-burst abandons the transaction; no response generated afterward.

Structure
REQ-027 Shared package tcm_axi_pkg: FSM state encoding, AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR constants.
REQ-028 Single sub-module tcm_pmem_axi_wbuf: one-entry W holding register (data, strb, last, full).

Verification
REQ-029 Single write addr 0x4000_0010, data 0xDEADBEEF, wr 4'hF, len 0 -> one AW (awlen 0), one W wlast=1 wstrb F; bresp OKAY -> one ram_ack_o, error 0.
REQ-030 4-beat write len 3, wready low every other cycle, awready delayed 5 cycles -> 4 W beats in order, wlast on 4th only, single ack after B.
REQ-031 4-beat read addr 0x0000_3FF8, len 3, R data 1..4 with rvalid gaps -> araddr 0x3FF8, arlen 3, four acks with data 1,2,3,4, back to IDLE after rlast.
REQ-032 Read with rresp=2'b10 on beat 2 -> ram_error_o 1 on that ack only.
REQ-033 Simultaneous rd and wr in IDLE -> only write burst issued; arvalid stays 0.
REQ-034 rst_i low during RDATA beat 2 -> all outputs reset same cycle; later requests start clean.

Source files
------------

// File: rtl/tcm_axi_pkg.sv
// Shared definitions for the TCM pmem/AXI bridge: FSM encoding and AXI4 constants.
package tcm_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/tcm_pmem_axi_wbuf.sv
// One-entry W channel holding register; a load may coincide with the drain of the
// previous entry, so the pmem side can stream one beat per cycle while wready is high.
module tcm_pmem_axi_wbuf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  strb_i,
    input  logic        last_i,
    input  logic        wready_i,
    output logic        full_o,
    output logic [31:0] data_o,
    output logic [3:0]  strb_o,
    output logic        last_o
);

    logic        full_q, full_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        last_q, last_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        strb_d = strb_q;
        last_d = last_q;
        if (full_q && wready_i) begin
            full_d = 1'b0;
        end
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            strb_d = strb_i;
            last_d = last_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            strb_q <= strb_d;
            last_q <= last_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign strb_o = strb_q;
    assign last_o = last_q;

endmodule

// File: rtl/tcm_pmem_axi.sv
// Pmem-to-AXI4 initiator: each pmem burst becomes one INCR transaction, one outstanding.
// state  | meaning
// IDLE   | accepting a new pmem request
// WRITE  | AW pending and/or W beats being collected and drained
// WRESP  | waiting for the burst's single B response
// RADDR  | AR pending
// RDATA  | forwarding R beats to the pmem side until rlast
module tcm_pmem_axi
    import tcm_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID  = 4'd0,
    parameter logic [7:0] MAX_LEN = 8'd7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ram_rd_i,
    input  logic [3:0]  ram_wr_i,
    input  logic [7:0]  ram_len_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_write_data_i,
    output logic        ram_accept_o,
    output logic        ram_ack_o,
    output logic        ram_error_o,
    output logic [31:0] ram_read_data_o,
    output logic        axi_awvalid_o,
    output logic [31:0] axi_awaddr_o,
    output logic [3:0]  axi_awid_o,
    output logic [7:0]  axi_awlen_o,
    output logic [1:0]  axi_awburst_o,
    input  logic        axi_awready_i,
    output logic        axi_wvalid_o,
    output logic [31:0] axi_wdata_o,
    output logic [3:0]  axi_wstrb_o,
    output logic        axi_wlast_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    input  logic [1:0]  axi_bresp_i,
    input  logic [3:0]  axi_bid_i,
    output logic        axi_bready_o,
    output logic        axi_arvalid_o,
    output logic [31:0] axi_araddr_o,
    output logic [3:0]  axi_arid_o,
    output logic [7:0]  axi_arlen_o,
    output logic [1:0]  axi_arburst_o,
    input  logic        axi_arready_i,
    input  logic        axi_rvalid_i,
    input  logic [31:0] axi_rdata_i,
    input  logic [1:0]  axi_rresp_i,
    input  logic [3:0]  axi_rid_i,
    input  logic        axi_rlast_i,
    output logic        axi_rready_o
);

    state_e      state_q, state_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        bready_q, bready_d;
    logic        rready_q, rready_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  beats_q, beats_d;
    logic        clamp_q, clamp_d;
    logic        aw_done_q, aw_done_d;
    logic        wl_done_q, wl_done_d;

    logic        accept;
    logic        w_load;
    logic        w_last_in;
    logic        w_full;
    logic        w_last;
    logic        wr_req;
    logic [7:0]  len_cl;
    logic        len_over;
    logic        aw_hs, wl_hs, b_hs, r_hs, ar_hs;
    logic        unused_addr;

    assign unused_addr = ^ram_addr_i[1:0];

    assign wr_req   = (ram_wr_i != 4'h0);
    assign len_cl   = clamp_len(ram_len_i, MAX_LEN);
    assign len_over = (ram_len_i > MAX_LEN);
    assign aw_hs    = awvalid_q & axi_awready_i;
    assign wl_hs    = w_full & axi_wready_i & w_last;
    assign b_hs     = bready_q & axi_bvalid_i;
    assign r_hs     = rready_q & axi_rvalid_i;
    assign ar_hs    = arvalid_q & axi_arready_i;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        beats_d   = beats_q;
        clamp_d   = clamp_q;
        aw_done_d = aw_done_q;
        wl_done_d = wl_done_q;
        accept    = 1'b0;
        w_load    = 1'b0;
        w_last_in = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = 1'b1;
                // A write request takes priority when rd and wr arrive together.
                if (wr_req) begin
                    w_load    = 1'b1;
                    w_last_in = (len_cl == 8'd0);
                    awvalid_d = 1'b1;
                    awaddr_d  = {ram_addr_i[31:2], 2'b00};
                    awlen_d   = len_cl;
                    beats_d   = len_cl;
                    clamp_d   = len_over;
                    aw_done_d = 1'b0;
                    wl_done_d = 1'b0;
                    state_d   = ST_WRITE;
                end else if (ram_rd_i) begin
                    arvalid_d = 1'b1;
                    araddr_d  = {ram_addr_i[31:2], 2'b00};
                    arlen_d   = len_cl;
                    clamp_d   = len_over;
                    state_d   = ST_RADDR;
                end
            end
            ST_WRITE: begin
                // beats_q counts W beats still to be collected from the pmem side.
                accept = (beats_q != 8'd0) & (~w_full | axi_wready_i);
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wl_hs) begin
                    wl_done_d = 1'b1;
                end
                if (accept && wr_req) begin
                    w_load    = 1'b1;
                    w_last_in = (beats_q == 8'd1);
                    beats_d   = beats_q - 8'd1;
                end
                if ((aw_done_q | aw_hs) && (wl_done_q | wl_hs)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    ack_d    = 1'b1;
                    err_d    = (axi_bresp_i != AXI_RESP_OKAY) | (axi_bid_i != AXI_ID) | clamp_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_hs) begin
                    ack_d   = 1'b1;
                    rdata_d = axi_rdata_i;
                    err_d   = (axi_rresp_i != AXI_RESP_OKAY) | (axi_rid_i != AXI_ID) | clamp_q;
                    if (axi_rlast_i) begin
                        rready_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            beats_q   <= '0;
            clamp_q   <= 1'b0;
            aw_done_q <= 1'b0;
            wl_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            beats_q   <= beats_d;
            clamp_q   <= clamp_d;
            aw_done_q <= aw_done_d;
            wl_done_q <= wl_done_d;
        end
    end

    tcm_pmem_axi_wbuf u_wbuf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (w_load),
        .data_i   (ram_write_data_i),
        .strb_i   (ram_wr_i),
        .last_i   (w_last_in),
        .wready_i (axi_wready_i),
        .full_o   (w_full),
        .data_o   (axi_wdata_o),
        .strb_o   (axi_wstrb_o),
        .last_o   (w_last)
    );

    assign ram_accept_o    = accept;
    assign ram_ack_o       = ack_q;
    assign ram_error_o     = err_q;
    assign ram_read_data_o = rdata_q;
    assign axi_awvalid_o   = awvalid_q;
    assign axi_awaddr_o    = awaddr_q;
    assign axi_awid_o      = AXI_ID;
    assign axi_awlen_o     = awlen_q;
    assign axi_awburst_o   = AXI_BURST_INCR;
    assign axi_wvalid_o    = w_full;
    assign axi_wlast_o     = w_last;
    assign axi_bready_o    = bready_q;
    assign axi_arvalid_o   = arvalid_q;
    assign axi_araddr_o    = araddr_q;
    assign axi_arid_o      = AXI_ID;
    assign axi_arlen_o     = arlen_q;
    assign axi_arburst_o   = AXI_BURST_INCR;
    assign axi_rready_o    = rready_q;

endmodule

// File: tb/tb_tcm_pmem_axi.sv
// Scoreboard bench for tcm_pmem_axi: random AXI responder plus a burst-level reference model.
`timescale 1ns/1ps
module tb_tcm_pmem_axi;

    localparam logic [3:0] ID  = 4'h5;
    localparam int         MAX = 7;

    logic        clk, rst_i;
    logic        ram_rd_i;
    logic [3:0]  ram_wr_i;
    logic [7:0]  ram_len_i;
    logic [31:0] ram_addr_i, ram_write_data_i;
    logic        ram_accept_o, ram_ack_o, ram_error_o;
    logic [31:0] ram_read_data_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_wvalid_o, axi_wlast_o, axi_wready_i;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i;
    logic [3:0]  axi_bid_i;
    logic        axi_arvalid_o, axi_arready_i;
    logic [31:0] axi_araddr_o;
    logic [3:0]  axi_arid_o;
    logic [7:0]  axi_arlen_o;
    logic [1:0]  axi_arburst_o;
    logic        axi_rvalid_i, axi_rlast_i, axi_rready_o;
    logic [31:0] axi_rdata_i;
    logic [1:0]  axi_rresp_i;
    logic [3:0]  axi_rid_i;

    tcm_pmem_axi #(.AXI_ID(ID), .MAX_LEN(8'd7)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ram_rd_i(ram_rd_i), .ram_wr_i(ram_wr_i), .ram_len_i(ram_len_i),
        .ram_addr_i(ram_addr_i), .ram_write_data_i(ram_write_data_i),
        .ram_accept_o(ram_accept_o), .ram_ack_o(ram_ack_o), .ram_error_o(ram_error_o),
        .ram_read_data_o(ram_read_data_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
        .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
        .axi_bready_o(axi_bready_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
        .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o), .axi_arready_i(axi_arready_i),
        .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
        .axi_rid_i(axi_rid_i), .axi_rlast_i(axi_rlast_i), .axi_rready_o(axi_rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [7:0] len; } addr_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bplan_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last; } rbeat_t;
    typedef struct { logic is_rd; logic [31:0] data; logic err; } ack_t;

    addr_t  exp_aw[$], exp_ar[$];
    wbeat_t exp_w[$];
    bplan_t b_plan[$];
    rbeat_t rd_plan[$], r_beats[$];
    ack_t   exp_ack[$];

    int total = 0, bad = 0;
    int aw_delay = 0, w_mode = 2, r_pct = 100;
    int aw_total = 0, wl_total = 0, b_total = 0, r_hs_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // AW responder: awready held off for aw_delay cycles of awvalid.
    initial begin
        int waited = 0;
        addr_t a;
        axi_awready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin axi_awready_i = 1'b0; waited = 0; aw_total = 0; continue; end
            axi_awready_i = axi_awvalid_o && ((waited >= aw_delay) || exp_aw.size() == 0);
            #1;
            if (axi_awvalid_o && axi_awready_i) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
                else begin
                    a = exp_aw.pop_front();
                    chk("awaddr", axi_awaddr_o, a.addr);
                    chk("awlen", 32'(axi_awlen_o), 32'(a.len));
                    chk("awburst", 32'(axi_awburst_o), 32'd1);
                    chk("awid", 32'(axi_awid_o), 32'(ID));
                end
                aw_total++;
                waited = 0;
            end else if (axi_awvalid_o) waited++;
        end
    end

    // W responder: mode 0 random, 1 alternating, 2 always ready.
    initial begin
        logic tog = 1'b0;
        wbeat_t w;
        axi_wready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin axi_wready_i = 1'b0; wl_total = 0; continue; end
            case (w_mode)
                0: axi_wready_i = 1'($urandom_range(0, 1));
                1: begin axi_wready_i = tog; tog = ~tog; end
                default: axi_wready_i = 1'b1;
            endcase
            #1;
            if (axi_wvalid_o && axi_wready_i) begin
                if (exp_w.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
                else begin
                    w = exp_w.pop_front();
                    chk("wdata", axi_wdata_o, w.data);
                    chk("wstrb", 32'(axi_wstrb_o), 32'(w.strb));
                    chk("wlast", 32'(axi_wlast_o), 32'(w.last));
                end
                if (axi_wlast_o) wl_total++;
            end
        end
    end

    // B responder: one response once both AW and the last W of a burst are seen.
    initial begin
        logic done = 1'b0;
        axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00; axi_bid_i = 4'h0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin axi_bvalid_i = 1'b0; done = 1'b0; b_total = 0; continue; end
            if (done) begin axi_bvalid_i = 1'b0; done = 1'b0; end
            if (!axi_bvalid_i && aw_total > b_total && wl_total > b_total &&
                b_plan.size() > 0 && $urandom_range(0, 1) == 1) begin
                axi_bvalid_i = 1'b1;
                axi_bresp_i  = b_plan[0].resp;
                axi_bid_i    = b_plan[0].id;
            end
            #1;
            if (axi_bvalid_i && axi_bready_o) begin
                void'(b_plan.pop_front());
                b_total++;
                done = 1'b1;
            end
        end
    end

    // AR responder: random arready; a handshake releases that burst's planned R beats.
    initial begin
        addr_t a;
        rbeat_t r;
        axi_arready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin axi_arready_i = 1'b0; continue; end
            axi_arready_i = 1'($urandom_range(0, 1)) || exp_ar.size() == 0;
            #1;
            if (axi_arvalid_o && axi_arready_i) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
                else begin
                    a = exp_ar.pop_front();
                    chk("araddr", axi_araddr_o, a.addr);
                    chk("arlen", 32'(axi_arlen_o), 32'(a.len));
                    chk("arburst", 32'(axi_arburst_o), 32'd1);
                    chk("arid", 32'(axi_arid_o), 32'(ID));
                    do begin
                        r = rd_plan.pop_front();
                        r_beats.push_back(r);
                    end while (!r.last && rd_plan.size() > 0);
                end
            end
        end
    end

    // R responder: beats with random gaps controlled by r_pct.
    initial begin
        logic done = 1'b0;
        axi_rvalid_i = 1'b0; axi_rdata_i = '0; axi_rresp_i = 2'b00; axi_rid_i = 4'h0; axi_rlast_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin axi_rvalid_i = 1'b0; done = 1'b0; r_beats.delete(); continue; end
            if (done) begin axi_rvalid_i = 1'b0; done = 1'b0; end
            if (!axi_rvalid_i && r_beats.size() > 0 && $urandom_range(1, 100) <= r_pct) begin
                axi_rvalid_i = 1'b1;
                axi_rdata_i  = r_beats[0].data;
                axi_rresp_i  = r_beats[0].resp;
                axi_rid_i    = r_beats[0].id;
                axi_rlast_i  = r_beats[0].last;
            end
            #1;
            if (axi_rvalid_i && axi_rready_o) begin
                void'(r_beats.pop_front());
                r_hs_total++;
                done = 1'b1;
            end
        end
    end

    // Ack monitor: every pmem ack is matched against the next expected response.
    initial begin
        ack_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_i && ram_ack_o) begin
                if (exp_ack.size() == 0) chk("ack_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_ack.pop_front();
                    chk("ack_error", 32'(ram_error_o), 32'(e.err));
                    if (e.is_rd) chk("ack_rdata", ram_read_data_o, e.data);
                end
            end
        end
    end

    task automatic flush_model();
        exp_aw.delete(); exp_ar.delete(); exp_w.delete();
        b_plan.delete(); rd_plan.delete(); exp_ack.delete();
    endtask

    task automatic wait_done();
        int guard = 0;
        while (exp_ack.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
        if (exp_ack.size() != 0) begin
            chk("ack_timeout", 32'(exp_ack.size()), 32'd0);
            flush_model();
        end
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] bresp,
                            input logic [3:0] bid, input logic also_rd);
        int cl = (len > MAX) ? MAX : len;
        logic [31:0] d[16];
        logic [3:0]  s[16];
        addr_t a; wbeat_t w; bplan_t b; ack_t k;
        a.addr = addr & ~32'd3; a.len = 8'(cl); exp_aw.push_back(a);
        b.resp = bresp; b.id = bid; b_plan.push_back(b);
        k.is_rd = 1'b0; k.data = '0; k.err = (len > MAX) || (bresp != 2'b00) || (bid != ID);
        exp_ack.push_back(k);
        for (int i = 0; i <= cl; i++) begin
            d[i] = $urandom; s[i] = 4'($urandom_range(1, 15));
            w.data = d[i]; w.strb = s[i]; w.last = (i == cl); exp_w.push_back(w);
        end
        for (int i = 0; i <= cl; i++) begin
            int guard = 0;
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                @(negedge clk); ram_wr_i = 4'h0; ram_rd_i = 1'b0;
            end
            @(negedge clk);
            ram_wr_i = s[i]; ram_write_data_i = d[i];
            ram_addr_i = (i == 0) ? addr : $urandom;
            ram_len_i  = (i == 0) ? 8'(len) : 8'($urandom);
            ram_rd_i   = (i == 0) ? also_rd : 1'b0;
            #1;
            while (!ram_accept_o && guard < 500) begin @(negedge clk); #1; guard++; end
            if (!ram_accept_o) begin
                chk("accept_timeout", 32'd0, 32'd1);
                flush_model();
                break;
            end
        end
        @(negedge clk);
        ram_wr_i = 4'h0; ram_rd_i = 1'b0;
        #1;
        if (also_rd) chk("arvalid_during_write", 32'(axi_arvalid_o), 32'd0);
        wait_done();
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input int err_beat,
                           input logic [3:0] rid, input logic seq_data, input logic wait_it);
        int cl = (len > MAX) ? MAX : len;
        addr_t a; rbeat_t r; ack_t k;
        a.addr = addr & ~32'd3; a.len = 8'(cl); exp_ar.push_back(a);
        for (int i = 0; i <= cl; i++) begin
            r.data = seq_data ? 32'(i + 1) : $urandom;
            r.resp = (i == err_beat) ? 2'b10 : 2'b00;
            r.id = rid; r.last = (i == cl);
            rd_plan.push_back(r);
            k.is_rd = 1'b1; k.data = r.data;
            k.err = (len > MAX) || (r.resp != 2'b00) || (rid != ID);
            exp_ack.push_back(k);
        end
        @(negedge clk);
        ram_rd_i = 1'b1; ram_wr_i = 4'h0; ram_addr_i = addr; ram_len_i = 8'(len);
        #1;
        chk("rd_accept", 32'(ram_accept_o), 32'd1);
        @(negedge clk);
        ram_rd_i = 1'b0;
        if (wait_it) wait_done();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_accept"}, 32'(ram_accept_o), 32'd1);
        chk({tag, "_ack"}, 32'(ram_ack_o), 32'd0);
        chk({tag, "_error"}, 32'(ram_error_o), 32'd0);
        chk({tag, "_rdata"}, ram_read_data_o, 32'd0);
        chk({tag, "_awvalid"}, 32'(axi_awvalid_o), 32'd0);
        chk({tag, "_wvalid"}, 32'(axi_wvalid_o), 32'd0);
        chk({tag, "_arvalid"}, 32'(axi_arvalid_o), 32'd0);
        chk({tag, "_bready"}, 32'(axi_bready_o), 32'd0);
        chk({tag, "_rready"}, 32'(axi_rready_o), 32'd0);
        chk({tag, "_awaddr"}, axi_awaddr_o, 32'd0);
        chk({tag, "_araddr"}, axi_araddr_o, 32'd0);
    endtask

    initial begin
        int guard;
        rst_i = 1'b0; ram_rd_i = 1'b0; ram_wr_i = 4'h0; ram_len_i = 8'd0;
        ram_addr_i = '0; ram_write_data_i = '0;
        #1;
        chk_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk_idle_outputs("post_reset");

        // Single-beat write.
        aw_delay = 0; w_mode = 2; r_pct = 100;
        do_write(32'h4000_0010, 0, 2'b00, ID, 1'b0);
        // Four beats, wready alternating, awready held off five cycles.
        aw_delay = 5; w_mode = 1;
        do_write(32'h0000_1000, 3, 2'b00, ID, 1'b0);
        // Four-beat read with gaps, data 1..4.
        aw_delay = 0; w_mode = 2; r_pct = 40;
        do_read(32'h0000_3FF8, 3, -1, ID, 1'b1, 1'b1);
        #1;
        chk("read_back_idle", 32'(ram_accept_o), 32'd1);
        chk("read_rready_low", 32'(axi_rready_o), 32'd0);
        // SLVERR on the second read beat only.
        do_read(32'h0000_2000, 3, 1, ID, 1'b0, 1'b1);
        // Read and write together: write wins.
        do_write(32'h0000_0044, 1, 2'b00, ID, 1'b1);
        // Length clamping and ID mismatches.
        do_write(32'h0000_0100, 10, 2'b00, ID, 1'b0);
        do_read(32'h0000_0200, 9, -1, ID, 1'b0, 1'b1);
        do_write(32'h0000_0300, 2, 2'b00, 4'h3, 1'b0);
        do_read(32'h0000_0400, 1, -1, 4'h9, 1'b0, 1'b1);
        do_write(32'h0000_0500, 0, 2'b10, ID, 1'b0);

        // Reset while the second read beat is in progress.
        r_pct = 30;
        do_read(32'h0000_0600, 3, -1, ID, 1'b1, 1'b0);
        guard = 0;
        while (exp_ack.size() > 3 && guard < 500) begin @(negedge clk); guard++; end
        chk("reset_test_first_beat", 32'(exp_ack.size()), 32'd3);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk_idle_outputs("midburst_reset");
        flush_model();
        r_beats.delete();
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("no_ack_after_reset", 32'(ram_ack_o), 32'd0);
        do_write(32'h0000_0700, 2, 2'b00, ID, 1'b0);
        do_read(32'h0000_0800, 2, -1, ID, 1'b0, 1'b1);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            int len = $urandom_range(0, 9);
            logic [3:0] id = ($urandom_range(0, 9) == 0) ? 4'hA : ID;
            aw_delay = $urandom_range(0, 3);
            w_mode = $urandom_range(0, 2);
            r_pct = $urandom_range(30, 100);
            if ($urandom_range(0, 1) == 0)
                do_write($urandom, len, ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00, id,
                         1'($urandom_range(0, 1)));
            else
                do_read($urandom & ~32'd3, len, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                        id, 1'b0, 1'b1);
        end

        repeat (5) @(negedge clk);
        chk("final_queues_empty", 32'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_ack.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
